ifq_multi: RTL and testbench

Parametrised instruction fetch queue between the fetcher/icache port and the decoder. It generates sequential fetch PCs and caps outstanding fetch requests with a credit scheme, so the queue can never overflow. Returned instructions are buffered with their PCs, and up to DEQ_W instructions per cycle are presented to decode. On a ROB redirect it flushes, and it silently drops any fetch responses that were already in flight, so no stale instruction ever enters the queue.

---
 rtl/ifq_multi_pkg.sv | 16 +
 rtl/ifq_multi_if.sv | 37 +++
 rtl/ifq_multi_store.sv | 31 +++
 rtl/ifq_multi.sv | 99 +++++++++
 tb/tb_ifq_multi.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ifq_multi_pkg.sv
// Shared constants and entry payload for the instruction fetch queue.
package ifq_multi_pkg;

  localparam int unsigned     XLEN     = 32;
  localparam int unsigned     INSTR_W  = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_1000;
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
  localparam logic            TRUE     = 1'b1;
  localparam logic            FALSE    = 1'b0;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } entry_t;

endpackage

// File: rtl/ifq_multi_if.sv
// Fetch request/response, redirect and decode-lane signals of the fetch queue.
interface ifq_multi_if
  import ifq_multi_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DEQ_W = 2
) ();

  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned DCNT_W = $clog2(DEQ_W + 1);

  logic                     flush;
  logic [XLEN-1:0]          flush_pc;
  logic                     req_valid;
  logic [XLEN-1:0]          req_pc;
  logic                     req_ready;
  logic                     rsp_valid;
  logic [INSTR_W-1:0]       rsp_instr;
  logic [DEQ_W-1:0]         deq_valid;
  logic [DEQ_W*INSTR_W-1:0] deq_instr;
  logic [DEQ_W*XLEN-1:0]    deq_pc;
  logic [DCNT_W-1:0]        deq_cnt;
  logic [CNT_W-1:0]         count;
  logic                     empty;
  logic                     full;

  modport master (
    input  flush, flush_pc, req_ready, rsp_valid, rsp_instr, deq_cnt,
    output req_valid, req_pc, deq_valid, deq_instr, deq_pc, count, empty, full
  );

  modport slave (
    output flush, flush_pc, req_ready, rsp_valid, rsp_instr, deq_cnt,
    input  req_valid, req_pc, deq_valid, deq_instr, deq_pc, count, empty, full
  );

endinterface

// File: rtl/ifq_multi_store.sv
// Queue storage: one write port, DEQ_W combinational read ports at base+k.
module ifq_multi_store
  import ifq_multi_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DEQ_W = 2
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  entry_t                     wdata,
  input  logic [$clog2(DEPTH)-1:0]   base,
  output entry_t [DEQ_W-1:0]         rdata
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read address wraps naturally because DEPTH is a power of two.
  always_comb begin
    for (int k = 0; k < DEQ_W; k++) begin
      rdata[k] = mem[base + AW'(k)];
    end
  end

endmodule

// File: rtl/ifq_multi.sv
// Instruction fetch queue: credit-limited sequential fetch, in-order buffering,
// multi-lane show-ahead dequeue, and redirect flush that drops in-flight responses.
module ifq_multi
  import ifq_multi_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned DEQ_W    = 2,
  parameter int unsigned MAX_PEND = 4
) (
  input logic         clk,
  input logic         rst,
  ifq_multi_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(MAX_PEND + 1);

  logic [PW-1:0]      head, tail, count, nvalid, take;
  logic [CW-1:0]      pend, drop, live;
  logic [XLEN-1:0]    fetch_pc, wr_pc;
  logic               req_fire, rsp_ok, rsp_drop, rsp_wr;
  entry_t             wr_entry;
  entry_t [DEQ_W-1:0] rd_data;

  assign count = tail - head;
  assign live  = pend - drop;

  // Live requests reserve a slot, so an accepted response always has room.
  assign bus.req_valid = !rst && !bus.flush && (32'(pend) < MAX_PEND) &&
                         ((32'(count) + 32'(live)) < DEPTH);
  assign bus.req_pc    = fetch_pc;
  assign req_fire      = bus.req_valid && bus.req_ready;

  assign rsp_ok   = bus.rsp_valid && (pend != '0);
  assign rsp_drop = rsp_ok && (drop != '0);
  assign rsp_wr   = rsp_ok && (drop == '0) && !bus.flush;

  assign nvalid = bus.flush ? '0 : ((32'(count) > DEQ_W) ? PW'(DEQ_W) : count);
  assign take   = (PW'(bus.deq_cnt) < nvalid) ? PW'(bus.deq_cnt) : nvalid;

  assign wr_entry.instr = bus.rsp_instr;
  assign wr_entry.pc    = wr_pc;

  ifq_multi_store #(.DEPTH(DEPTH), .DEQ_W(DEQ_W)) u_store (
    .clk   (clk),
    .we    (rsp_wr),
    .waddr (tail[AW-1:0]),
    .wdata (wr_entry),
    .base  (head[AW-1:0]),
    .rdata (rd_data)
  );

  for (genvar k = 0; k < DEQ_W; k++) begin : g_lane
    assign bus.deq_valid[k]                   = 32'(nvalid) > 32'(k);
    assign bus.deq_instr[k*INSTR_W +: INSTR_W] = rd_data[k].instr;
    assign bus.deq_pc[k*XLEN +: XLEN]          = rd_data[k].pc;
  end

  assign bus.count = count;
  assign bus.empty = (count == '0) ? TRUE : FALSE;
  assign bus.full  = (32'(count) == DEPTH) ? TRUE : FALSE;

  // Flush wins over everything; every response still in flight becomes stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      pend     <= '0;
      drop     <= '0;
      fetch_pc <= RESET_PC;
      wr_pc    <= RESET_PC;
    end else if (bus.flush) begin
      head     <= '0;
      tail     <= '0;
      pend     <= pend - CW'(rsp_ok);
      drop     <= pend - CW'(rsp_ok);
      fetch_pc <= bus.flush_pc;
      wr_pc    <= bus.flush_pc;
    end else begin
      head <= head + take;
      pend <= pend + CW'(req_fire) - CW'(rsp_ok);
      if (rsp_drop) drop <= drop - CW'(1);
      if (rsp_wr) begin
        tail  <= tail + PW'(1);
        wr_pc <= wr_pc + PC_STEP;
      end
      if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
    end
  end

  a_rsp_needs_pend: assert property (@(posedge clk) disable iff (rst)
    !(bus.rsp_valid && (pend == '0)));
  a_no_over_consume: assert property (@(posedge clk) disable iff (rst)
    bus.flush || (PW'(bus.deq_cnt) <= nvalid));
  a_drop_le_pend: assert property (@(posedge clk) disable iff (rst)
    drop <= pend);

endmodule

// File: tb/tb_ifq_multi.sv
// Directed bench for ifq_multi with an in-bench in-order fetcher model.
module tb_ifq_multi;
  import ifq_multi_pkg::*;

  localparam int unsigned DEPTH    = 16;
  localparam int unsigned DEQ_W    = 2;
  localparam int unsigned MAX_PEND = 4;

  logic clk = 1'b0;
  logic rst;

  ifq_multi_if #(.DEPTH(DEPTH), .DEQ_W(DEQ_W)) bus ();

  ifq_multi #(.DEPTH(DEPTH), .DEQ_W(DEQ_W), .MAX_PEND(MAX_PEND)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          n_fire = 0;
  logic        rsp_en;
  logic [31:0] fq[$];

  logic        s_req_valid;
  logic [31:0] s_req_pc;
  logic [1:0]  s_deq_valid;
  logic [31:0] s_pc[2];
  logic [31:0] s_instr[2];
  logic [4:0]  s_count;
  logic        s_empty, s_full, s_rsp;

  int unsigned m_cnt, mx, dc, consumed;
  logic [31:0] exp_pc;

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return ~pc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive fetcher response, sample at negedge, update fetcher queue.
  task automatic tick();
    if (rsp_en && fq.size() > 0) begin
      bus.rsp_valid = 1'b1;
      bus.rsp_instr = ins_of(fq[0]);
    end else begin
      bus.rsp_valid = 1'b0;
      bus.rsp_instr = '0;
    end
    @(negedge clk);
    s_req_valid = bus.req_valid;
    s_req_pc    = bus.req_pc;
    s_deq_valid = bus.deq_valid;
    s_count     = bus.count;
    s_empty     = bus.empty;
    s_full      = bus.full;
    s_rsp       = bus.rsp_valid;
    for (int k = 0; k < 2; k++) begin
      s_pc[k]    = bus.deq_pc[k*32 +: 32];
      s_instr[k] = bus.deq_instr[k*32 +: 32];
    end
    if (bus.rsp_valid) void'(fq.pop_front());
    if (bus.req_valid && bus.req_ready) begin
      fq.push_back(bus.req_pc);
      n_fire++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.flush_pc = '0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_instr = '0;
    bus.deq_cnt = '0;
    rsp_en = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_req_valid", 32'(s_req_valid), 32'd0);
    chk("rst_req_pc", s_req_pc, 32'h1000);
    chk("rst_deq_valid", 32'(s_deq_valid), 32'd0);
    chk("rst_count", 32'(s_count), 32'd0);
    chk("rst_empty", 32'(s_empty), 32'd1);
    chk("rst_full", 32'(s_full), 32'd0);

    // Sequential fetch with a 1-cycle fetcher
    rst = 1'b0;
    bus.req_ready = 1'b1;
    rsp_en = 1'b1;
    tick();
    chk("seq_req_valid", 32'(s_req_valid), 32'd1);
    chk("seq_req_pc0", s_req_pc, 32'h1000);
    tick();
    chk("seq_req_pc1", s_req_pc, 32'h1004);
    chk("seq_deq_not_yet", 32'(s_deq_valid), 32'd0);
    tick();
    chk("seq_req_pc2", s_req_pc, 32'h1008);
    chk("seq_deq_valid", 32'(s_deq_valid), 32'b01);
    chk("seq_deq_pc0", s_pc[0], 32'h1000);
    chk("seq_deq_instr0", s_instr[0], ~32'h1000);
    chk("seq_count", 32'(s_count), 32'd1);

    // Fill without dequeue
    repeat (25) tick();
    tick();
    chk("fill_full", 32'(s_full), 32'd1);
    chk("fill_count", 32'(s_count), 32'd16);
    chk("fill_req_valid", 32'(s_req_valid), 32'd0);
    chk("fill_pend_zero", 32'(fq.size()), 32'd0);
    chk("fill_fires", 32'(n_fire), 32'd16);

    bus.deq_cnt = 2'd2;
    tick();
    chk("full_deq_valid", 32'(s_deq_valid), 32'b11);
    chk("full_deq_pc0", s_pc[0], 32'h1000);
    chk("full_deq_pc1", s_pc[1], 32'h1004);
    chk("full_req_blocked", 32'(s_req_valid), 32'd0);
    bus.deq_cnt = 2'd0;
    tick();
    chk("after_deq_count", 32'(s_count), 32'd14);
    chk("after_deq_req_valid", 32'(s_req_valid), 32'd1);
    chk("after_deq_req_pc", s_req_pc, 32'h1040);
    bus.req_ready = 1'b0;
    tick();

    // Drain down to 3 entries, then two-lane dequeue
    bus.deq_cnt = 2'd2;
    repeat (6) tick();
    tick();
    chk("two_lane_count", 32'(s_count), 32'd3);
    chk("two_lane_valid", 32'(s_deq_valid), 32'b11);
    chk("two_lane_pc0", s_pc[0], 32'h1038);
    chk("two_lane_pc1", s_pc[1], 32'h103C);
    chk("two_lane_instr1", s_instr[1], ~32'h103C);
    bus.deq_cnt = 2'd0;
    tick();
    chk("one_lane_count", 32'(s_count), 32'd1);
    chk("one_lane_valid", 32'(s_deq_valid), 32'b01);
    chk("one_lane_pc0", s_pc[0], 32'h1040);

    // Flush with three requests outstanding and no response that cycle
    bus.req_ready = 1'b1;
    rsp_en = 1'b0;
    repeat (3) tick();
    bus.req_ready = 1'b0;
    bus.flush = 1'b1;
    bus.flush_pc = 32'h2000;
    tick();
    chk("flush_req_valid", 32'(s_req_valid), 32'd0);
    chk("flush_deq_valid", 32'(s_deq_valid), 32'd0);
    bus.flush = 1'b0;
    rsp_en = 1'b1;
    tick();
    chk("flush_req_pc", s_req_pc, 32'h2000);
    chk("flush_count", 32'(s_count), 32'd0);
    chk("flush_empty", 32'(s_empty), 32'd1);
    tick();
    tick();
    bus.req_ready = 1'b1;
    tick();
    chk("flush_drop3_count", 32'(s_count), 32'd0);
    bus.req_ready = 1'b0;
    tick();
    tick();
    chk("flush_first_count", 32'(s_count), 32'd1);
    chk("flush_first_pc", s_pc[0], 32'h2000);
    chk("flush_next_req_pc", s_req_pc, 32'h2004);

    // Flush coinciding with a response while two requests are outstanding
    rsp_en = 1'b0;
    bus.req_ready = 1'b1;
    tick();
    tick();
    bus.req_ready = 1'b0;
    rsp_en = 1'b1;
    bus.flush = 1'b1;
    bus.flush_pc = 32'h3000;
    tick();
    chk("cflush_deq_valid", 32'(s_deq_valid), 32'd0);
    chk("cflush_req_valid", 32'(s_req_valid), 32'd0);
    bus.flush = 1'b0;
    tick();
    chk("cflush_count", 32'(s_count), 32'd0);
    chk("cflush_req_pc", s_req_pc, 32'h3000);
    bus.req_ready = 1'b1;
    tick();
    chk("cflush_dropped", 32'(s_count), 32'd0);
    bus.req_ready = 1'b0;
    tick();
    tick();
    chk("cflush_first_count", 32'(s_count), 32'd1);
    chk("cflush_first_pc", s_pc[0], 32'h3000);
    chk("cflush_first_instr", s_instr[0], ~32'h3000);

    // Pointer wrap: random stalls and random consumption
    m_cnt = 1;
    exp_pc = 32'h3000;
    consumed = 0;
    for (int it = 0; it < 2000 && consumed < 40; it++) begin
      bus.req_ready = ($urandom_range(0, 3) != 0);
      rsp_en = ($urandom_range(0, 3) != 0);
      mx = (m_cnt < 2) ? m_cnt : 2;
      dc = $urandom_range(0, mx);
      bus.deq_cnt = 2'(dc);
      tick();
      chk("wrap_count", 32'(s_count), m_cnt);
      chk("wrap_count_bound", 32'(s_count <= 5'd16), 32'd1);
      for (int k = 0; k < 2; k++) begin
        chk("wrap_lane_valid", 32'(s_deq_valid[k]), 32'(m_cnt > 32'(k)));
        if (m_cnt > 32'(k)) begin
          chk("wrap_lane_pc", s_pc[k], exp_pc + 32'(4 * k));
          chk("wrap_lane_instr", s_instr[k], ~(exp_pc + 32'(4 * k)));
        end
      end
      m_cnt = m_cnt - dc + (s_rsp ? 1 : 0);
      exp_pc = exp_pc + 32'(4 * dc);
      consumed = consumed + dc;
    end
    bus.deq_cnt = '0;
    chk("wrap_progress", 32'(consumed >= 40), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
